// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch stage.
//   state_t          fetch FSM state encoding
//   IFETCH_RESET_PC  default PC value loaded on reset
//   INSTR_W          instruction word width
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W         = 32;

endpackage

// File: rtl/instr_fetch_pc_update.sv
// pc_update: program counter register with branch/jump load logic.
// Ports:
//   clock, reset_n              clock, async active-low reset
//   pc_write                    unconditional load
//   pc_write_cond, branch_op    conditional load (BEQ when branch_op=0, BNE when 1)
//   zero                        ALU zero flag
//   pc_src                      0 selects alu_result, 1 selects alu_out
//   alu_result, alu_out         candidate next-PC values
//   pc                          current program counter
//   load                        PC is loaded at the next edge
module pc_update #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic              branch_op,
  input  logic              zero,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] alu_out,
  output logic [ADDR_W-1:0] pc,
  output logic              load
);

  // branch_op inverts the sense of zero: BEQ takes on zero, BNE on !zero.
  assign load = pc_write | (pc_write_cond & (zero ^ branch_op));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= pc_src ? alu_out : alu_result;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC and instruction register; performs one handshaked
// instruction-memory read per accepted fetch_req and holds the result for decode.
// Optional build macro: IFETCH_MISALIGN_TRAP_EN (misaligned-fetch trap, FAULT state).
// Ports:
//   clock, reset_n          clock, async active-low reset
//   fetch_req               request next instruction (level, sampled per cycle)
//   imem_req/imem_addr      read request and address to instruction memory
//   imem_ack/imem_rdata     memory accept and returned word
//   instr_valid             instruction/instr_pc hold a fetched word
//   instruction, instr_pc   instruction register and its fetch address
//   pc                      current program counter
//   pc_write, pc_write_cond, branch_op, zero, pc_src, alu_result, alu_out
//                           PC update controls from control unit and ALU
//   fetch_fault             misaligned fetch flag (0 unless trap enabled)
//
// state | meaning
// IDLE  | no instruction fetched since reset
// FETCH | memory request outstanding, waiting for imem_ack
// HOLD  | instruction register valid and frozen
// FAULT | last fetch attempt was misaligned (trap build only)
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFETCH_RESET_PC)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               fetch_req,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc,
  input  logic               pc_write,
  input  logic               pc_write_cond,
  input  logic               branch_op,
  input  logic               zero,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  alu_result,
  input  logic [ADDR_W-1:0]  alu_out,
  output logic               fetch_fault
);

  state_t            state;
  logic [ADDR_W-1:0] fetch_addr;
  logic              unused_pc_load;

  pc_update #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_update (
    .clock         (clock),
    .reset_n       (reset_n),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_op     (branch_op),
    .zero          (zero),
    .pc_src        (pc_src),
    .alu_result    (alu_result),
    .alu_out       (alu_out),
    .pc            (pc),
    .load          (unused_pc_load)
  );

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign imem_addr = fetch_addr;
`else
  assign imem_addr   = {fetch_addr[ADDR_W-1:2], 2'b00};
  assign fetch_fault = 1'b0;
`endif

  // fetch_addr is captured from the pre-update pc, so a same-cycle or later
  // PC load never disturbs the read already in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fetch_addr  <= '0;
      imem_req    <= 1'b0;
      instruction <= '0;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instruction <= imem_rdata;
            instr_pc    <= fetch_addr;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        default: begin
          if (fetch_req) begin
            instr_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (pc[1:0] != 2'b00) begin
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end else begin
              fetch_fault <= 1'b0;
              fetch_addr  <= pc;
              imem_req    <= 1'b1;
              state       <= FETCH;
            end
`else
            fetch_addr <= pc;
            imem_req   <= 1'b1;
            state      <= FETCH;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] pc;
  logic        pc_write;
  logic        pc_write_cond;
  logic        branch_op;
  logic        zero;
  logic        pc_src;
  logic [31:0] alu_result;
  logic [31:0] alu_out;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc_q[$];

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .fetch_req     (fetch_req),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .pc            (pc),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_op     (branch_op),
    .zero          (zero),
    .pc_src        (pc_src),
    .alu_result    (alu_result),
    .alu_out       (alu_out),
    .fetch_fault   (fetch_fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle PC-update pulse; checks the resulting pc afterwards.
  task automatic pc_load(input logic wr, input logic cond, input logic bop, input logic z,
                         input logic src, input logic [31:0] res, input logic [31:0] aout,
                         input logic [31:0] exp_pc, input string tag);
    pc_write = wr; pc_write_cond = cond; branch_op = bop; zero = z;
    pc_src = src; alu_result = res; alu_out = aout;
    @(negedge clock);
    pc_write = 1'b0; pc_write_cond = 1'b0;
    check(tag, pc, exp_pc);
  endtask

  task automatic start_fetch(input logic [31:0] exp_addr);
    fetch_req = 1'b1;
    @(negedge clock);
    fetch_req = 1'b0;
    check("req_rise", {31'd0, imem_req}, 32'd1);
    check("req_addr", imem_addr, exp_addr);
    check("valid_low_at_req", {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic finish_fetch(input logic [31:0] word, input int waits,
                              input logic [31:0] exp_addr, input logic [31:0] exp_ipc);
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      check("wait_req_held", {31'd0, imem_req}, 32'd1);
      check("wait_addr_stable", imem_addr, exp_addr);
      check("wait_valid_low", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    exp_instr_q.push_back(word);
    exp_pc_q.push_back(exp_ipc);
    @(negedge clock);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    check("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    check("req_drop_after_ack", {31'd0, imem_req}, 32'd0);
    check("sb_depth", exp_instr_q.size(), 32'd1);
    if (exp_instr_q.size() > 0) begin
      check("instruction", instruction, exp_instr_q.pop_front());
      check("instr_pc", instr_pc, exp_pc_q.pop_front());
    end
  endtask

  initial begin
    reset_n = 1'b0; fetch_req = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    pc_write = 1'b0; pc_write_cond = 1'b0; branch_op = 1'b0; zero = 1'b0;
    pc_src = 1'b0; alu_result = '0; alu_out = '0;
    repeat (2) @(negedge clock);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_ipc", instr_pc, 32'h0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // minimum-latency fetch, then delayed ack
    start_fetch(32'h0);
    finish_fetch(32'h0050_0093, 0, 32'h0, 32'h0);
    start_fetch(32'h0);
    finish_fetch(32'h1234_5678, 3, 32'h0, 32'h0);

    // ack outside FETCH must not touch the instruction register
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    imem_ack = 1'b0;
    check("hold_ignore_ack", instruction, 32'h1234_5678);
    check("hold_valid", {31'd0, instr_valid}, 32'd1);

    // unconditional load from alu_result, then fetch from it
    pc_load(1, 0, 0, 0, 0, 32'h4, 32'h999, 32'h4, "pcw_alu_result");
    start_fetch(32'h4);
    finish_fetch(32'hA5A5_0001, 1, 32'h4, 32'h4);

    // conditional branches
    pc_load(0, 1, 0, 1, 1, 32'h300, 32'h40, 32'h40, "beq_taken");
    pc_load(0, 1, 0, 0, 1, 32'h300, 32'h44, 32'h40, "beq_not_taken");
    pc_load(0, 1, 1, 0, 1, 32'h300, 32'h48, 32'h48, "bne_taken");
    pc_load(0, 1, 1, 1, 1, 32'h300, 32'h4C, 32'h48, "bne_not_taken");
    pc_load(0, 0, 1, 0, 1, 32'h300, 32'h50, 32'h48, "no_load");

    // pc_write while FETCH is in flight
    start_fetch(32'h48);
    pc_load(1, 0, 0, 0, 0, 32'h80, 32'h0, 32'h80, "pcw_in_fetch");
    check("inflight_addr", imem_addr, 32'h48);
    finish_fetch(32'hCAFE_0002, 1, 32'h48, 32'h48);

    // pc update and fetch accepted in the same cycle: fetch uses old pc
    fetch_req = 1'b1; pc_write = 1'b1; pc_src = 1'b0; alu_result = 32'h100;
    @(negedge clock);
    fetch_req = 1'b0; pc_write = 1'b0;
    check("same_cycle_addr", imem_addr, 32'h80);
    check("same_cycle_pc", pc, 32'h100);
    finish_fetch(32'hBEEF_0003, 0, 32'h80, 32'h80);

    // reset during FETCH, late ack ignored
    start_fetch(32'h100);
    #2 reset_n = 1'b0;
    #1 check("rst_async_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    imem_ack = 1'b0;
    check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("late_ack_req", {31'd0, imem_req}, 32'd0);
    check("late_ack_pc", pc, 32'h0);
    check("late_ack_instr", instruction, 32'h0);

`ifdef IFETCH_MISALIGN_TRAP_EN
    pc_load(1, 0, 0, 0, 0, 32'h6, 32'h0, 32'h6, "pc_misaligned");
    fetch_req = 1'b1;
    @(negedge clock);
    fetch_req = 1'b0;
    check("fault_set", {31'd0, fetch_fault}, 32'd1);
    check("fault_no_req", {31'd0, imem_req}, 32'd0);
    check("fault_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clock);
    check("fault_still_no_req", {31'd0, imem_req}, 32'd0);
    pc_load(1, 0, 0, 0, 0, 32'h8, 32'h0, 32'h8, "pc_realigned");
    start_fetch(32'h8);
    check("fault_cleared", {31'd0, fetch_fault}, 32'd0);
    finish_fetch(32'h0000_0013, 0, 32'h8, 32'h8);
`else
    pc_load(1, 0, 0, 0, 0, 32'h6, 32'h0, 32'h6, "pc_misaligned");
    start_fetch(32'h4);
    check("no_fault", {31'd0, fetch_fault}, 32'd0);
    finish_fetch(32'h0000_0013, 0, 32'h4, 32'h6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
